uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Bus-side controller that sequences the UART byte serializer. Accepts core stores on the peripheral bus, buffers transmit bytes in a small FIFO, and issues them one at a time to the serializer over a valid/ready handshake. Also generates the baud-rate tick and exposes status and configuration registers to software. Sits between the core's data-memory bus decoder and the UART serializer.

## Interface
- FIFO_DEPTH, 8: transmit FIFO entries; power of two, 2..16
- DIV_W, 16: baud divisor width
- DEFAULT_DIV, 868: divisor loaded at reset (100 MHz / 115200)
- CLOCK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- req_i  in  1  bus request, one cycle per access
- we_i  in  1  1 = write, 0 = read
- addr_i  in  4  byte offset: 0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV, 0xC CTRL
- DATA_i  in  32  write data
- rdata_o  out  32  read data, registered
- tx_valid_o  out  1  byte offered to serializer
- tx_byte_o  out  8  byte being offered
- tx_ready_i  in  1  serializer idle and accepting
- baud_tick_o  out  1  one-cycle pulse per bit period
- irq_o  out  1  TX-empty interrupt (see Configuration)

## Operation
- Registers:
  - TXDATA, write-only: pushes DATA_i[7:0]; reads return 0.
  - STATUS, read-only: [0] empty, [1] full, [2] overflow (sticky), [3] busy (FSM ≠ IDLE), [8+:4] FIFO count.
  - BAUDDIV: [DIV_W-1:0].
  - CTRL: [0] en, [1] write-1 clears overflow, [2] write-1 flushes FIFO, [3] irq_en. Bits [1] and [2] read 0.
- Push is accepted if the FIFO is not full, or if a pop happens in the same cycle. Otherwise the byte is dropped and overflow is set.
- FSM states: IDLE, ISSUE, SETTLE.
  - IDLE → ISSUE when en=1 and the FIFO is non-empty. On this transition the head byte is latched into tx_byte_o and popped.
  - ISSUE: tx_valid_o=1. On tx_valid_o & tx_ready_i → SETTLE.
  - SETTLE: tx_valid_o=0. → ISSUE (latch and pop) if en=1 and the FIFO is non-empty; otherwise → IDLE.
- tx_valid_o and tx_byte_o are stable from assertion until the handshake. Clearing en or flushing during ISSUE does not withdraw the offered byte.
- Flush empties the FIFO. It does not clear overflow. If flush and push occur in the same cycle, flush wins and the byte is discarded.
- Baud counter runs only while en=1.
  - Effective divisor is max(BAUDDIV,1). baud_tick_o pulses once every effective-divisor cycles.
  - A BAUDDIV write reloads the counter, so the first tick follows a full period.
- Unmapped offsets: writes are ignored; reads return 0.

## Timing
- Reset values:
  - Outputs: rdata_o=0, tx_valid_o=0, tx_byte_o=0, baud_tick_o=0, irq_o=0.
  - Internal: FSM=IDLE, FIFO empty, overflow=0, BAUDDIV=DEFAULT_DIV, en=1, irq_en=0, baud counter reloaded.
- Read: rdata_o is valid the cycle after req_i & !we_i, and holds until the next read.
- Write: takes effect at the clock edge ending the request cycle.
- Latency from TXDATA write in cycle N (FIFO empty, FSM IDLE):
  - FIFO count=1 at N+1.
  - tx_valid_o=1 and count=0 at N+2.
- Minimum spacing between issued bytes is 2 cycles (ISSUE, SETTLE).
- Reset asserted mid-operation: all state returns to reset values immediately. tx_valid_o drops asynchronously and buffered bytes are lost.

## Configuration
- UART_TX_IRQ_EN defined:
  - irq_o = irq_en & empty & (FSM == IDLE), registered.
  - CTRL[3] is read/write.
- UART_TX_IRQ_EN undefined:
  - irq_o is tied to 0.
  - CTRL[3] ignores writes and reads 0.

## Structure
- Package uart_pkg holds:
  - register offset constants;
  - STATUS and CTRL bit-index constants;
  - the FSM state enum (IDLE, ISSUE, SETTLE);
  - DEFAULT_DIV.
- Sub-module uart_tx_fifo: synchronous FIFO with push, pop, flush, full, empty and count, sized by FIFO_DEPTH.
- The baud counter, register file and FSM live in uart_tx_ctrl.

## Test plan
- Reset, read STATUS → 0x0000_0001; read BAUDDIV → 868; all outputs 0.
- Write TXDATA 0x41 with tx_ready_i=1 → tx_valid_o=1 and tx_byte_o=0x41 two cycles after the write; SETTLE then IDLE; STATUS.busy returns 0.
- Hold tx_ready_i=0 and write 9 bytes 0x00..0x08 (DEPTH=8):
  - after the first pop, the FIFO holds the last 8 bytes with no overflow;
  - a tenth write gives STATUS.full=1 and overflow=1;
  - writing CTRL=0x3 clears overflow.
- Write BAUDDIV=4 → baud_tick_o pulses every 4 cycles. BAUDDIV=0 → pulses every cycle. en=0 → no pulses.
- Mid-ISSUE, clear en and flush:
  - tx_byte_o holds until tx_ready_i rises, then the FSM reaches IDLE;
  - the FIFO count is 0;
  - assert RESET mid-ISSUE → tx_valid_o=0 immediately.
- With UART_TX_IRQ_EN and irq_en=1: irq_o=1 when idle and empty, drops within 1 cycle after a TXDATA write. Without the macro, irq_o stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit controller.
//   - register byte offsets (TXDATA, STATUS, BAUDDIV, CTRL)
//   - STATUS and CTRL bit positions
//   - transmit sequencer state encoding
//   - DEFAULT_DIV: divisor for 115200 baud from a 100 MHz clock
package uart_pkg;

  localparam logic [3:0] ADDR_TXDATA  = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_BAUDDIV = 4'h8;
  localparam logic [3:0] ADDR_CTRL    = 4'hC;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_BUSY_BIT  = 3;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 4;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_OVF_CLR_BIT = 1;
  localparam int CTRL_FLUSH_BIT   = 2;
  localparam int CTRL_IRQ_EN_BIT  = 3;

  localparam int DEFAULT_DIV = 868;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: bus and serializer signals of the UART transmit controller.
//   master : bus decoder / serializer side (drives req, we, addr, data, tx_ready)
//   slave  : the controller (drives rdata, tx_valid, tx_byte, baud_tick, irq)
interface uart_tx_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] DATA_i;
  logic [31:0] rdata_o;
  logic        tx_valid_o;
  logic [7:0]  tx_byte_o;
  logic        tx_ready_i;
  logic        baud_tick_o;
  logic        irq_o;

  modport master (
    output req_i, we_i, addr_i, DATA_i, tx_ready_i,
    input  rdata_o, tx_valid_o, tx_byte_o, baud_tick_o, irq_o
  );

  modport slave (
    input  req_i, we_i, addr_i, DATA_i, tx_ready_i,
    output rdata_o, tx_valid_o, tx_byte_o, baud_tick_o, irq_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO buffering transmit bytes.
//   CLOCK, RESET      : clock, asynchronous active-high reset
//   push_i/push_data_i: enqueue request and byte
//   pop_i             : dequeue the head entry
//   flush_i           : empty the FIFO; beats a simultaneous push
//   head_o            : current head entry
//   full_o, empty_o, count_o : occupancy
// A push into a full FIFO is still accepted when a pop frees a slot in
// the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign push_ok_s = push_i & (~full_s | pop_i) & ~flush_i;
  assign pop_ok_s  = pop_i & ~empty_s;

  // Storage array write port
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data_i;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Read/write pointers and occupancy count
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_o  = mem_r[rd_ptr_r];
  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign count_o = count_r;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: bus-side sequencer for the UART byte serializer.
//   CLOCK : single clock, rising edge
//   RESET : asynchronous active-high reset
//   bus   : uart_tx_ctrl_if.slave -- register bus (req/we/addr/DATA/rdata),
//           serializer handshake (tx_valid/tx_byte/tx_ready), baud_tick, irq
// Registers: 0x0 TXDATA (push), 0x4 STATUS, 0x8 BAUDDIV, 0xC CTRL.
// Build option: define UART_TX_IRQ_EN to enable the TX-empty interrupt
// (CTRL[3] becomes read/write); otherwise irq_o is tied low.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
  input logic           CLOCK,
  input logic           RESET,
  uart_tx_ctrl_if.slave bus
);
  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             wr_s, rd_s;
  logic             wr_txdata_s, wr_baud_s, wr_ctrl_s;
  logic             flush_s, ovf_clr_s, drop_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;
  logic [7:0]       fifo_head_s;
  tx_state_e        state_r, next_state_s;
  logic             pop_s;
  logic             en_r, irq_en_r, ovf_r, irq_r;
  logic [DIV_W-1:0] baud_div_r, baud_cnt_r, eff_div_s;
  logic             baud_tick_r, tx_valid_r;
  logic [7:0]       tx_byte_r;
  logic [31:0]      rdata_r, rd_val_s, status_s, ctrl_s, count_ext_s;
  logic             unused_data_s;

  // Bus decode: writes act on the edge that ends the request cycle
  assign wr_s        = bus.req_i & bus.we_i;
  assign rd_s        = bus.req_i & ~bus.we_i;
  assign wr_txdata_s = wr_s & (bus.addr_i == ADDR_TXDATA);
  assign wr_baud_s   = wr_s & (bus.addr_i == ADDR_BAUDDIV);
  assign wr_ctrl_s   = wr_s & (bus.addr_i == ADDR_CTRL);
  assign flush_s     = wr_ctrl_s & bus.DATA_i[CTRL_FLUSH_BIT];
  assign ovf_clr_s   = wr_ctrl_s & bus.DATA_i[CTRL_OVF_CLR_BIT];
  // A push is dropped only if full with no same-cycle pop; a flush discards silently
  assign drop_s      = wr_txdata_s & fifo_full_s & ~pop_s & ~flush_s;
  assign unused_data_s = ^bus.DATA_i;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .push_i      (wr_txdata_s),
    .push_data_i (bus.DATA_i[7:0]),
    .pop_i       (pop_s),
    .flush_i     (flush_s),
    .head_o      (fifo_head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  // Sequencer state register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sequencer next state; pop_s also latches the head byte into tx_byte
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE, SETTLE: begin
        if (en_r && !fifo_empty_s) begin
          next_state_s = ISSUE;
          pop_s        = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      // Offered byte stays up until taken, regardless of en or flush
      ISSUE: begin
        if (bus.tx_ready_i) begin
          next_state_s = SETTLE;
        end else begin
          next_state_s = ISSUE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Registered serializer handshake outputs
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      tx_valid_r <= 1'b0;
      tx_byte_r  <= 8'h00;
    end else begin
      tx_valid_r <= (next_state_s == ISSUE);
      if (pop_s) begin
        tx_byte_r <= fifo_head_s;
      end else begin
        tx_byte_r <= tx_byte_r;
      end
    end
  end

  // Configuration and sticky overflow registers
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      baud_div_r <= DIV_W'(DEFAULT_DIV);
      en_r       <= 1'b1;
      ovf_r      <= 1'b0;
    end else begin
      if (wr_baud_s) begin
        baud_div_r <= bus.DATA_i[DIV_W-1:0];
      end else begin
        baud_div_r <= baud_div_r;
      end
      if (wr_ctrl_s) begin
        en_r <= bus.DATA_i[CTRL_EN_BIT];
      end else begin
        en_r <= en_r;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // A zero divisor behaves like one: tick every cycle
  assign eff_div_s = (baud_div_r == {DIV_W{1'b0}}) ? DIV_W'(1) : baud_div_r;

  // Baud counter; a BAUDDIV write restarts a full period
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      baud_cnt_r  <= {DIV_W{1'b0}};
      baud_tick_r <= 1'b0;
    end else if (wr_baud_s) begin
      baud_cnt_r  <= {DIV_W{1'b0}};
      baud_tick_r <= 1'b0;
    end else if (en_r) begin
      if (baud_cnt_r >= eff_div_s - DIV_W'(1)) begin
        baud_cnt_r  <= {DIV_W{1'b0}};
        baud_tick_r <= 1'b1;
      end else begin
        baud_cnt_r  <= baud_cnt_r + DIV_W'(1);
        baud_tick_r <= 1'b0;
      end
    end else begin
      baud_cnt_r  <= baud_cnt_r;
      baud_tick_r <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_next_s;
  // irq anticipates the FIFO leaving empty so it drops right after a push
  assign irq_next_s = irq_en_r & fifo_empty_s & (~wr_txdata_s | flush_s) &
                      (next_state_s == IDLE);

  // Interrupt enable and registered TX-empty interrupt
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        irq_en_r <= bus.DATA_i[CTRL_IRQ_EN_BIT];
      end else begin
        irq_en_r <= irq_en_r;
      end
      irq_r <= irq_next_s;
    end
  end
`else
  assign irq_en_r = 1'b0;
  assign irq_r    = 1'b0;
`endif

  // STATUS and CTRL read images
  always_comb begin
    count_ext_s = 32'(fifo_count_s);
    status_s    = 32'h0000_0000;
    status_s[STATUS_EMPTY_BIT] = fifo_empty_s;
    status_s[STATUS_FULL_BIT]  = fifo_full_s;
    status_s[STATUS_OVF_BIT]   = ovf_r;
    status_s[STATUS_BUSY_BIT]  = (state_r != IDLE);
    status_s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count_ext_s[STATUS_COUNT_W-1:0];
    ctrl_s = 32'h0000_0000;
    ctrl_s[CTRL_EN_BIT]     = en_r;
    ctrl_s[CTRL_IRQ_EN_BIT] = irq_en_r;
  end

  // Read data mux; TXDATA and unmapped offsets read zero
  always_comb begin
    rd_val_s = 32'h0000_0000;
    case (bus.addr_i)
      ADDR_STATUS:  rd_val_s = status_s;
      ADDR_BAUDDIV: rd_val_s = 32'(baud_div_r);
      ADDR_CTRL:    rd_val_s = ctrl_s;
      default:      rd_val_s = 32'h0000_0000;
    endcase
  end

  // Registered read data, held until the next read
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rdata_r <= 32'h0000_0000;
    end else if (rd_s) begin
      rdata_r <= rd_val_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign bus.rdata_o     = rdata_r;
  assign bus.tx_valid_o  = tx_valid_r;
  assign bus.tx_byte_o   = tx_byte_r;
  assign bus.baud_tick_o = baud_tick_r;
  assign bus.irq_o       = irq_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: self-checking bench for uart_tx_ctrl (FIFO_DEPTH=8).
// Register accesses come from a vector table; expected read data and
// expected serializer bytes are queued at stimulus time and popped when
// the DUT answers. Honours UART_TX_IRQ_EN for the interrupt checks.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  logic CLOCK;
  logic RESET;
  int   checks;
  int   failures;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(
    .FIFO_DEPTH  (8),
    .DIV_W       (16),
    .DEFAULT_DIV (868)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

`ifdef UART_TX_IRQ_EN
  localparam logic [31:0] CTRL_F_RB = 32'h0000_0009;
`else
  localparam logic [31:0] CTRL_F_RB = 32'h0000_0001;
`endif

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[16];
  logic [31:0] rd_exp_q[$];
  logic [7:0]  byte_exp_q[$];
  logic [15:0] pat;

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = a;
    bus.DATA_i = d;
    @(posedge CLOCK);
    #1;
    bus.req_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.DATA_i = 32'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    logic [31:0] e;
    rd_exp_q.push_back(exp);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = a;
    @(posedge CLOCK);
    #1;
    bus.req_i = 1'b0;
    e = rd_exp_q.pop_front();
    chk(name, bus.rdata_o, e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (byte_exp_q.size() != 0 && n < 60) begin
      @(posedge CLOCK);
      #1;
      n++;
    end
    chk(name, 32'(byte_exp_q.size()), 32'h0);
  endtask

  // Serializer side: every accepted byte must be the next expected one
  always @(negedge CLOCK) begin
    if (!RESET && bus.tx_valid_o && bus.tx_ready_i) begin
      if (byte_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL handshake_unexpected actual=0x%02h required=none", bus.tx_byte_o);
      end else begin
        chk("handshake_byte", 32'(bus.tx_byte_o), 32'(byte_exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    checks = 0;
    failures = 0;
    RESET = 1'b1;
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
    bus.addr_i = 4'h0;
    bus.DATA_i = 32'h0;
    bus.tx_ready_i = 1'b0;

    vecs[0]  = '{1'b0, ADDR_STATUS,  32'h0,         32'h0000_0001};
    vecs[1]  = '{1'b0, ADDR_BAUDDIV, 32'h0,         32'd868};
    vecs[2]  = '{1'b0, ADDR_CTRL,    32'h0,         32'h0000_0001};
    vecs[3]  = '{1'b0, ADDR_TXDATA,  32'h0,         32'h0000_0000};
    vecs[4]  = '{1'b0, 4'h1,         32'h0,         32'h0000_0000};
    vecs[5]  = '{1'b1, ADDR_BAUDDIV, 32'h1234_ABCD, 32'h0};
    vecs[6]  = '{1'b0, ADDR_BAUDDIV, 32'h0,         32'h0000_ABCD};
    vecs[7]  = '{1'b1, 4'h2,         32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, 4'h2,         32'h0,         32'h0000_0000};
    vecs[9]  = '{1'b1, 4'h6,         32'h0000_0041, 32'h0};
    vecs[10] = '{1'b0, ADDR_STATUS,  32'h0,         32'h0000_0001};
    vecs[11] = '{1'b1, ADDR_CTRL,    32'h0000_000F, 32'h0};
    vecs[12] = '{1'b0, ADDR_CTRL,    32'h0,         CTRL_F_RB};
    vecs[13] = '{1'b0, ADDR_STATUS,  32'h0,         32'h0000_0001};
    vecs[14] = '{1'b1, ADDR_BAUDDIV, 32'd868,       32'h0};
    vecs[15] = '{1'b0, ADDR_BAUDDIV, 32'h0,         32'd868};

    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_tx_valid", 32'(bus.tx_valid_o), 32'h0);
    chk("rst_tx_byte", 32'(bus.tx_byte_o), 32'h0);
    chk("rst_baud_tick", 32'(bus.baud_tick_o), 32'h0);
    chk("rst_irq", 32'(bus.irq_o), 32'h0);
    RESET = 1'b0;
    idle(1);

    // Register file vectors
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, vecs[i].exp, $sformatf("reg_vec%0d", i));
      end
    end

    // Single byte: count=1 at N+1, offered at N+2, then SETTLE and IDLE
    bus.tx_ready_i = 1'b1;
    byte_exp_q.push_back(8'h41);
    bus_write(ADDR_TXDATA, 32'h0000_0041);
    chk("t2_valid_n1", 32'(bus.tx_valid_o), 32'h0);
    bus_read(ADDR_STATUS, 32'h0000_0100, "t2_status_n1");
    chk("t2_valid_n2", 32'(bus.tx_valid_o), 32'h1);
    chk("t2_byte_n2", 32'(bus.tx_byte_o), 32'h41);
    bus_read(ADDR_STATUS, 32'h0000_0009, "t2_status_issue");
    chk("t2_valid_settle", 32'(bus.tx_valid_o), 32'h0);
    bus_read(ADDR_STATUS, 32'h0000_0009, "t2_status_settle");
    bus_read(ADDR_STATUS, 32'h0000_0001, "t2_status_idle");

    // Fill with the serializer stalled: 9 writes fit, the tenth overflows
    bus.tx_ready_i = 1'b0;
    for (int b = 0; b < 9; b++) begin
      byte_exp_q.push_back(8'(b));
      bus_write(ADDR_TXDATA, 32'(b));
    end
    bus_read(ADDR_STATUS, 32'h0000_080A, "t3_full_no_ovf");
    chk("t3_head_offered", 32'(bus.tx_byte_o), 32'h00);
    bus_write(ADDR_TXDATA, 32'h0000_0009);
    bus_read(ADDR_STATUS, 32'h0000_080E, "t3_overflow");
    bus_write(ADDR_CTRL, 32'h0000_0003);
    bus_read(ADDR_STATUS, 32'h0000_080A, "t3_ovf_cleared");
    bus.tx_ready_i = 1'b1;
    wait_drain("t3_drain");
    idle(2);
    bus_read(ADDR_STATUS, 32'h0000_0001, "t3_status_after");

    // Baud tick spacing: divisor 4, divisor 0, and disabled
    bus_write(ADDR_BAUDDIV, 32'd4);
    for (int k = 0; k < 16; k++) begin
      pat[k] = bus.baud_tick_o;
      idle(1);
    end
    chk("t4_div4_pattern", 32'(pat), 32'h0000_1110);
    bus_write(ADDR_BAUDDIV, 32'd0);
    for (int k = 0; k < 16; k++) begin
      pat[k] = bus.baud_tick_o;
      idle(1);
    end
    chk("t4_div0_pattern", 32'(pat), 32'h0000_FFFE);
    bus_write(ADDR_CTRL, 32'h0000_0000);
    idle(1);
    for (int k = 0; k < 16; k++) begin
      pat[k] = bus.baud_tick_o;
      idle(1);
    end
    chk("t4_en0_pattern", 32'(pat), 32'h0000_0000);
    bus_write(ADDR_CTRL, 32'h0000_0001);
    bus_write(ADDR_BAUDDIV, 32'd868);

    // Clear en and flush while a byte is offered
    bus.tx_ready_i = 1'b0;
    byte_exp_q.push_back(8'hA1);
    bus_write(ADDR_TXDATA, 32'h0000_00A1);
    bus_write(ADDR_TXDATA, 32'h0000_00A2);
    bus_write(ADDR_TXDATA, 32'h0000_00A3);
    bus_write(ADDR_CTRL, 32'h0000_0004);
    idle(2);
    chk("t5_valid_held", 32'(bus.tx_valid_o), 32'h1);
    chk("t5_byte_held", 32'(bus.tx_byte_o), 32'hA1);
    bus_read(ADDR_STATUS, 32'h0000_0009, "t5_flushed");
    bus.tx_ready_i = 1'b1;
    wait_drain("t5_drain");
    idle(2);
    bus_read(ADDR_STATUS, 32'h0000_0001, "t5_idle");
    bus.tx_ready_i = 1'b0;
    bus_write(ADDR_TXDATA, 32'h0000_00B5);
    idle(3);
    chk("t5_en0_no_issue", 32'(bus.tx_valid_o), 32'h0);
    bus_read(ADDR_STATUS, 32'h0000_0100, "t5_en0_status");

    // Reset in the middle of ISSUE
    bus_write(ADDR_CTRL, 32'h0000_0001);
    n = 0;
    while (!bus.tx_valid_o && n < 10) begin
      idle(1);
      n++;
    end
    chk("t5_issue_before_reset", 32'(bus.tx_valid_o), 32'h1);
    #2;
    RESET = 1'b1;
    #1;
    chk("t5_async_valid_drop", 32'(bus.tx_valid_o), 32'h0);
    chk("t5_async_byte_clear", 32'(bus.tx_byte_o), 32'h0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    idle(1);
    bus_read(ADDR_STATUS, 32'h0000_0001, "t5_post_reset_status");
    bus_read(ADDR_BAUDDIV, 32'd868, "t5_post_reset_div");
    bus_read(ADDR_CTRL, 32'h0000_0001, "t5_post_reset_ctrl");

    // TX-empty interrupt
    bus_write(ADDR_CTRL, 32'h0000_0009);
`ifdef UART_TX_IRQ_EN
    idle(1);
    chk("t6_irq_idle", 32'(bus.irq_o), 32'h1);
    bus.tx_ready_i = 1'b1;
    byte_exp_q.push_back(8'h55);
    bus_write(ADDR_TXDATA, 32'h0000_0055);
    chk("t6_irq_drop", 32'(bus.irq_o), 32'h0);
    wait_drain("t6_drain");
    idle(3);
    chk("t6_irq_back", 32'(bus.irq_o), 32'h1);
`else
    bus_read(ADDR_CTRL, 32'h0000_0001, "t6_ctrl_irq_en_ignored");
    idle(1);
    chk("t6_irq_tied_idle", 32'(bus.irq_o), 32'h0);
    bus.tx_ready_i = 1'b1;
    byte_exp_q.push_back(8'h55);
    bus_write(ADDR_TXDATA, 32'h0000_0055);
    wait_drain("t6_drain");
    idle(3);
    chk("t6_irq_tied_after", 32'(bus.irq_o), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
